mole_board_ctrl: RTL and testbench

Round sequencer for the whack-a-mole board. Raises one mole at a pseudo-random hole, arms the downstream `board_timer` with the up-time, and scores the round: a hit on the lit hole or expiry of the timer. The block drives `board_timer`'s `load`/`loadval` and consumes its `time_trigger`. Score, miss count and game-over feed the display stage.

---
 rtl/mole_pkg.sv | 25 ++
 rtl/mole_board_if.sv | 37 +++
 rtl/mole_board_ctrl_lfsr.sv | 26 ++
 rtl/mole_board_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mole_board_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round sequencer.
package mole_pkg;

    localparam int TIMER_W = 28;
    localparam int CNT_W   = 8;
    localparam int LFSR_W  = 16;

    // Fibonacci taps 16,14,13,11 expressed as a bit mask over state[15:0].
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPAWN,
        ST_UP,
        ST_SHOW,
        ST_GAP,
        ST_DONE
    } board_state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mole_board_if.sv
// Bundle between the round sequencer and its surroundings: player inputs,
// the board_timer load/trigger pair and the display-facing status.
interface mole_board_if
    import mole_pkg::*;
#(
    parameter int N_HOLES = 9
) ();

    logic                 start;
    logic [N_HOLES-1:0]   hit_btn;
    logic                 time_trigger;
    logic                 load;
    logic [TIMER_W-1:0]   loadval;
    logic [N_HOLES-1:0]   mole;
    logic                 hit_flash;
    logic                 hit_pulse;
    logic                 miss_pulse;
    logic [CNT_W-1:0]     score;
    logic [CNT_W-1:0]     misses;
    logic [CNT_W-1:0]     round_cnt;
    logic                 game_over;

    // The sequencer side.
    modport master (
        input  start, hit_btn, time_trigger,
        output load, loadval, mole, hit_flash, hit_pulse, miss_pulse,
               score, misses, round_cnt, game_over
    );

    // The board / timer / display side.
    modport slave (
        output start, hit_btn, time_trigger,
        input  load, loadval, mole, hit_flash, hit_pulse, miss_pulse,
               score, misses, round_cnt, game_over
    );

endinterface

// File: rtl/mole_board_ctrl_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that free-runs every cycle.
module mole_lfsr
    import mole_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] i_seed,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] r_state;

    // Shift left, feeding back the XOR of the tapped bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= i_seed;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values, independent of block order.
            r_state <= {r_state[LFSR_W-2:0], ^(r_state & LFSR_TAPS)};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/mole_board_ctrl.sv
// Whack-a-mole round sequencer: picks a hole, arms board_timer, scores
// the round as a hit or a miss, and counts rounds until game over.
// Optional build macro: MOLE_SPEEDUP_EN shortens the up-time after each hit.
module mole_board_ctrl
    import mole_pkg::*;
#(
    parameter int                 N_HOLES    = 9,
    parameter logic [TIMER_W-1:0] UP_TICKS   = 28'd100_000_000,
    parameter logic [TIMER_W-1:0] SHOW_TICKS = 28'd25_000_000,
    parameter logic [TIMER_W-1:0] GAP_TICKS  = 28'd50_000_000,
    parameter logic [CNT_W-1:0]   ROUNDS     = 8'd30,
    parameter logic [TIMER_W-1:0] SPEED_STEP = 28'd5_000_000,
    parameter logic [TIMER_W-1:0] MIN_UP     = 28'd20_000_000,
    parameter logic [LFSR_W-1:0]  LFSR_SEED  = 16'hACE1
) (
    input  logic           clk,
    input  logic           rst,
    mole_board_if.master   io_bus
);

    localparam int HOLE_W = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;

    board_state_t         r_state;
    logic                 r_load;
    logic [TIMER_W-1:0]   r_loadval;
    logic [N_HOLES-1:0]   r_mole;
    logic [HOLE_W-1:0]    r_prev_hole;
    logic                 r_hit_flash;
    logic                 r_hit_pulse;
    logic                 r_miss_pulse;
    logic [CNT_W-1:0]     r_score;
    logic [CNT_W-1:0]     r_misses;
    logic [CNT_W-1:0]     r_round_cnt;
    logic                 r_game_over;

    logic [LFSR_W-1:0]    w_lfsr;
    logic [HOLE_W-1:0]    w_cand;
    logic [HOLE_W-1:0]    w_cand_next;
    logic [HOLE_W-1:0]    w_hole;
    logic [N_HOLES-1:0]   w_hole_onehot;
    logic                 w_trig;
    logic                 w_hit;
    logic [CNT_W-1:0]     w_round_next;
    logic [TIMER_W-1:0]   w_up_time;
    logic                 w_unused_bits;

    mole_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_seed  (LFSR_SEED),
        .o_state (w_lfsr)
    );

    // Hole choice: low LFSR byte folded onto the board, bumped by one if it
    // would light the same hole twice in a row.
    assign w_cand        = HOLE_W'(w_lfsr[7:0] % 8'(N_HOLES));
    assign w_cand_next   = (w_cand == HOLE_W'(N_HOLES - 1)) ? '0 : w_cand + HOLE_W'(1);
    assign w_hole        = (w_cand == r_prev_hole) ? w_cand_next : w_cand;
    assign w_hole_onehot = N_HOLES'(1) << w_hole;

    // A trigger or press landing with a load still in flight belongs to the
    // previous timer period; ignoring both also keeps load from going high
    // on two consecutive cycles.
    assign w_trig = io_bus.time_trigger & ~r_load;
    assign w_hit  = (|(io_bus.hit_btn & r_mole)) & ~r_load;

    assign w_round_next = r_round_cnt + CNT_W'(1);

`ifdef MOLE_SPEEDUP_EN
    logic [TIMER_W-1:0] r_up_time;
    logic [TIMER_W-1:0] w_up_faster;

    // Compare before subtracting so the floor clamp never underflows.
    assign w_up_faster = ((r_up_time > MIN_UP) && ((r_up_time - MIN_UP) >= SPEED_STEP))
                         ? r_up_time - SPEED_STEP : MIN_UP;
    assign w_up_time   = r_up_time;
    assign w_unused_bits = ^w_lfsr[15:8];
`else
    assign w_up_time   = UP_TICKS;
    // Speed-up tuning has no effect when the up-time is fixed.
    assign w_unused_bits = ^{w_lfsr[15:8], SPEED_STEP, MIN_UP};
`endif

    // Round sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_load       <= 1'b0;
            r_loadval    <= '0;
            r_mole       <= '0;
            r_prev_hole  <= '0;
            r_hit_flash  <= 1'b0;
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;
            r_score      <= '0;
            r_misses     <= '0;
            r_round_cnt  <= '0;
            r_game_over  <= 1'b0;
`ifdef MOLE_SPEEDUP_EN
            r_up_time    <= UP_TICKS;
`endif
        end else begin
            // NOTE: strobes default low every cycle and are raised only by
            // the transition that owns them, so each lasts exactly one cycle.
            r_load       <= 1'b0;
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (io_bus.start) begin
                        r_score     <= '0;
                        r_misses    <= '0;
                        r_round_cnt <= '0;
                        r_game_over <= 1'b0;
`ifdef MOLE_SPEEDUP_EN
                        r_up_time   <= UP_TICKS;
`endif
                        r_state     <= ST_SPAWN;
                    end
                end

                ST_SPAWN: begin
                    r_mole      <= w_hole_onehot;
                    r_prev_hole <= w_hole;
                    r_load      <= 1'b1;
                    r_loadval   <= w_up_time;
                    r_state     <= ST_UP;
                end

                ST_UP: begin
                    if (w_hit) begin
                        r_hit_pulse <= 1'b1;
                        r_score     <= sat_inc(r_score);
                        r_mole      <= '0;
                        r_load      <= 1'b1;
                        r_loadval   <= SHOW_TICKS;
                        r_hit_flash <= 1'b1;
`ifdef MOLE_SPEEDUP_EN
                        r_up_time   <= w_up_faster;
`endif
                        r_state     <= ST_SHOW;
                    end else if (w_trig) begin
                        r_miss_pulse <= 1'b1;
                        r_misses     <= sat_inc(r_misses);
                        r_mole       <= '0;
                        r_load       <= 1'b1;
                        r_loadval    <= GAP_TICKS;
                        r_state      <= ST_GAP;
                    end
                end

                ST_SHOW: begin
                    if (w_trig) begin
                        r_hit_flash <= 1'b0;
                        r_load      <= 1'b1;
                        r_loadval   <= GAP_TICKS;
                        r_state     <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (w_trig) begin
                        r_round_cnt <= w_round_next;
                        if (w_round_next == ROUNDS) begin
                            r_game_over <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_state     <= ST_SPAWN;
                        end
                    end
                end

                default: begin
                    r_mole      <= '0;
                    r_hit_flash <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.load       = r_load;
    assign io_bus.loadval    = r_loadval;
    assign io_bus.mole       = r_mole;
    assign io_bus.hit_flash  = r_hit_flash;
    assign io_bus.hit_pulse  = r_hit_pulse;
    assign io_bus.miss_pulse = r_miss_pulse;
    assign io_bus.score      = r_score;
    assign io_bus.misses     = r_misses;
    assign io_bus.round_cnt  = r_round_cnt;
    assign io_bus.game_over  = r_game_over;

endmodule

// File: tb/tb_mole_board_ctrl.sv
// Directed bench for mole_board_ctrl with a behavioural board_timer and an
// independent LFSR/hole model. Build with MOLE_SPEEDUP_EN for the speed-up run.
module tb_mole_board_ctrl;
    import mole_pkg::*;

    localparam int                 N      = 4;
    localparam logic [TIMER_W-1:0] UP     = 28'd20;
    localparam logic [TIMER_W-1:0] SHOW   = 28'd5;
    localparam logic [TIMER_W-1:0] GAP    = 28'd8;
    localparam logic [CNT_W-1:0]   ROUNDS = 8'd3;
    localparam logic [TIMER_W-1:0] STEP   = 28'd6;
    localparam logic [TIMER_W-1:0] MINUP  = 28'd10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mole_board_if #(.N_HOLES(N)) board_bus ();

    mole_board_ctrl #(
        .N_HOLES    (N),
        .UP_TICKS   (UP),
        .SHOW_TICKS (SHOW),
        .GAP_TICKS  (GAP),
        .ROUNDS     (ROUNDS),
        .SPEED_STEP (STEP),
        .MIN_UP     (MINUP),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (board_bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Behavioural board_timer: loads on load, counts down, pulses at zero.
    logic [TIMER_W-1:0] tmr_cnt;
    logic               tmr_fire;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_cnt  <= '0;
            tmr_fire <= 1'b0;
        end else begin
            tmr_fire <= 1'b0;
            if (board_bus.load) begin
                tmr_cnt <= board_bus.loadval;
            end else if (tmr_cnt != 0) begin
                tmr_cnt <= tmr_cnt - 1'b1;
                if (tmr_cnt == 1) tmr_fire <= 1'b1;
            end
        end
    end
    assign board_bus.time_trigger = tmr_fire;

    // Reference LFSR; m_prev holds the value the DUT used on the last edge.
    logic [15:0] m_lfsr, m_prev;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    int m_prev_hole;

    // Called at the negedge right after a SPAWN load edge.
    task automatic spawn_check(input string tag);
        int c;
        c = int'(m_prev[7:0]) % N;
        if (c == m_prev_hole) c = (c + 1) % N;
        check(tag, 32'(board_bus.mole), 32'(1) << c);
        m_prev_hole = c;
    endtask

    // Bounded wait for an observable event, sampled on negedges.
    task automatic wait_for(input int sel, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            case (sel)
                0: ok = board_bus.load && (board_bus.mole != 0);
                1: ok = board_bus.miss_pulse;
                2: ok = board_bus.game_over;
                3: ok = board_bus.time_trigger;
                5: ok = (board_bus.load && (board_bus.mole != 0)) || board_bus.game_over;
                default: ok = 1'b0;
            endcase
            if (ok) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit                 ok;
        logic [N-1:0]       saved;
        logic [N-1:0]       last_mole;
        int                 flash_cnt;
        int                 repeats;
        int                 loads;
        logic [TIMER_W-1:0] exp_up [3];

        rst               = 1'b1;
        board_bus.start   = 1'b0;
        board_bus.hit_btn = '0;
        m_prev_hole       = 0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_load",      32'(board_bus.load),      0);
        check("rst_loadval",   32'(board_bus.loadval),   0);
        check("rst_mole",      32'(board_bus.mole),      0);
        check("rst_score",     32'(board_bus.score),     0);
        check("rst_game_over", 32'(board_bus.game_over), 0);
        rst = 1'b0;
        @(negedge clk);

        // Start: load two cycles after the start pulse
        board_bus.start = 1'b1;
        @(negedge clk);
        board_bus.start = 1'b0;
        check("start_spawn_no_load", 32'(board_bus.load), 0);
        @(negedge clk);
        check("start_load",      32'(board_bus.load),    1);
        check("start_loadval",   32'(board_bus.loadval), 20);
        spawn_check("start_mole");
        check("start_onehot",    32'($countones(board_bus.mole)), 1);
        check("start_game_over", 32'(board_bus.game_over), 0);

        // Timeout: no presses
        wait_for(1, 40, ok);
        check("timeout_seen",    32'(ok),                1);
        check("timeout_misses",  32'(board_bus.misses),  1);
        check("timeout_load",    32'(board_bus.load),    1);
        check("timeout_loadval", 32'(board_bus.loadval), 8);
        check("timeout_mole",    32'(board_bus.mole),    0);
        check("timeout_score",   32'(board_bus.score),   0);

        // Round 2: wrong hole, then hit
        wait_for(0, 30, ok);
        check("r2_spawn_seen", 32'(ok),                  1);
        check("r2_round_cnt",  32'(board_bus.round_cnt), 1);
        check("r2_loadval",    32'(board_bus.loadval),   20);
        spawn_check("r2_mole");
        @(negedge clk);
        saved = board_bus.mole;
        board_bus.hit_btn = ~saved;
        @(negedge clk);
        board_bus.hit_btn = '0;
        check("wrong_no_hit", 32'(board_bus.hit_pulse), 0);
        check("wrong_score",  32'(board_bus.score),     0);
        check("wrong_mole",   32'(board_bus.mole),      32'(saved));
        board_bus.hit_btn = saved;
        @(negedge clk);
        board_bus.hit_btn = '0;
        check("hit_pulse",   32'(board_bus.hit_pulse), 1);
        check("hit_score",   32'(board_bus.score),     1);
        check("hit_load",    32'(board_bus.load),      1);
        check("hit_loadval", 32'(board_bus.loadval),   5);
        check("hit_mole",    32'(board_bus.mole),      0);
        check("hit_flash",   32'(board_bus.hit_flash), 1);
        flash_cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (board_bus.load) begin
                ok = 1'b1;
                break;
            end
            if (board_bus.hit_flash) flash_cnt++;
        end
        // Timer sees load one edge late and fires one edge after reaching 0:
        // six more flash cycles after the hit cycle with SHOW_TICKS=5.
        check("show_end_seen",  32'(ok),                  1);
        check("show_flash_len", 32'(flash_cnt),           6);
        check("show_end_flash", 32'(board_bus.hit_flash), 0);
        check("show_gap_load",  32'(board_bus.loadval),   8);

        // Round 3: hit coincident with the timer trigger
        wait_for(0, 30, ok);
        check("r3_spawn_seen", 32'(ok),                  1);
        check("r3_round_cnt",  32'(board_bus.round_cnt), 2);
`ifdef MOLE_SPEEDUP_EN
        check("r3_loadval",    32'(board_bus.loadval),   14);
`else
        check("r3_loadval",    32'(board_bus.loadval),   20);
`endif
        spawn_check("r3_mole");
        wait_for(3, 40, ok);
        check("sim_trig_seen", 32'(ok), 1);
        board_bus.hit_btn = board_bus.mole;
        @(negedge clk);
        board_bus.hit_btn = '0;
        check("sim_hit_pulse",  32'(board_bus.hit_pulse),  1);
        check("sim_miss_pulse", 32'(board_bus.miss_pulse), 0);
        check("sim_misses",     32'(board_bus.misses),     1);
        check("sim_score",      32'(board_bus.score),      2);
        check("sim_loadval",    32'(board_bus.loadval),    5);

        // Game end
        wait_for(2, 60, ok);
        check("end_seen",      32'(ok),                  1);
        check("end_round_cnt", 32'(board_bus.round_cnt), 3);
        check("end_mole",      32'(board_bus.mole),      0);
        check("end_score",     32'(board_bus.score),     2);
        check("end_misses",    32'(board_bus.misses),    1);
        repeat (20) @(negedge clk);
        check("done_hold_over", 32'(board_bus.game_over), 1);
        check("done_no_load",   32'(board_bus.load),      0);
        board_bus.start = 1'b1;
        @(negedge clk);
        board_bus.start = 1'b0;
        check("restart_score",  32'(board_bus.score),     0);
        check("restart_misses", 32'(board_bus.misses),    0);
        check("restart_round",  32'(board_bus.round_cnt), 0);
        check("restart_over",   32'(board_bus.game_over), 0);

        // Game 2: every round hit; up-time sequence depends on the build
`ifdef MOLE_SPEEDUP_EN
        exp_up[0] = 28'd20; exp_up[1] = 28'd14; exp_up[2] = 28'd10;
`else
        exp_up[0] = 28'd20; exp_up[1] = 28'd20; exp_up[2] = 28'd20;
`endif
        last_mole = '0;
        for (int r = 0; r < 3; r++) begin
            wait_for(0, 40, ok);
            check("g2_spawn_seen", 32'(ok), 1);
            check("g2_up_loadval", 32'(board_bus.loadval), 32'(exp_up[r]));
            spawn_check("g2_mole");
            last_mole = board_bus.mole;
            @(negedge clk);
            board_bus.hit_btn = board_bus.mole;
            @(negedge clk);
            board_bus.hit_btn = '0;
            check("g2_hit_pulse", 32'(board_bus.hit_pulse), 1);
        end
        wait_for(2, 60, ok);
        check("g2_over_seen", 32'(ok),              1);
        check("g2_score",     32'(board_bus.score), 3);

        // 200 spawns: model match and no consecutive repeat
        repeats = 0;
        for (int s = 0; s < 200; s++) begin
            wait_for(5, 80, ok);
            if (ok && board_bus.game_over) begin
                board_bus.start = 1'b1;
                @(negedge clk);
                board_bus.start = 1'b0;
                wait_for(0, 10, ok);
            end
            if (!ok) begin
                check("rep_spawn_timeout", 32'(ok), 1);
                break;
            end
            spawn_check("rep_model");
            if (board_bus.mole == last_mole) repeats++;
            last_mole = board_bus.mole;
        end
        check("rep_no_repeat", 32'(repeats), 0);

        // Asynchronous reset while a mole is up
        @(negedge clk);
        check("pre_rst_mole_up", 32'(board_bus.mole != 0), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_mole",      32'(board_bus.mole),      0);
        check("arst_load",      32'(board_bus.load),      0);
        check("arst_loadval",   32'(board_bus.loadval),   0);
        check("arst_misses",    32'(board_bus.misses),    0);
        check("arst_round_cnt", 32'(board_bus.round_cnt), 0);
        check("arst_game_over", 32'(board_bus.game_over), 0);
        m_prev_hole = 0;
        @(negedge clk);
        rst = 1'b0;
        loads = 0;
        repeat (10) begin
            @(negedge clk);
            if (board_bus.load) loads++;
        end
        check("post_rst_no_load", 32'(loads), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
